// File: rtl/bootmem_ctrl.sv
// Boot memory controller: fixed boot image in the low ROM_WORDS words and
// scratch RAM above it. The RAM is zero-cleared after every reset, one word
// per cycle. Reads are registered, with a one-cycle latency and an rvalid strobe.
// Writes to the image region are refused and set a sticky err flag.
// Optional feature: define BOOTMEM_PATCH_EN to add the patch_unlock port and a
// single-word patch slot. An unlocked write into the image region fills the slot,
// and later reads of that address return the patched word.
module bootmem_ctrl #(
    parameter int DW        = 16,
    parameter int AW        = 5,
    parameter int ROM_WORDS = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cs,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    input  logic          clr_err,
`ifdef BOOTMEM_PATCH_EN
    input  logic          patch_unlock,
`endif
    output logic          ready,
    output logic [DW-1:0] dout,
    output logic          rvalid,
    output logic          err
);

    localparam int            DEPTH   = 1 << AW;
    localparam logic [AW-1:0] ROM_LIM = AW'(ROM_WORDS);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t        state;
    logic [AW-1:0] clr_ptr;

    // The entries below ROM_LIM are never written or read. Keeping the array
    // at full depth lets addr index it directly.
    logic [DW-1:0] mem [0:DEPTH-1];

    logic          rd_acc;
    logic          wr_ram;
    logic          wr_rom;
    logic          err_set;
    logic          clr_we;
    logic [DW-1:0] rd_word;

`ifdef BOOTMEM_PATCH_EN
    logic          patch_vld;
    logic [AW-1:0] patch_addr;
    logic [DW-1:0] patch_data;
    logic          patch_ld;
`endif

    // Fixed boot image. The word is zero-extended above bit 15, and words past
    // the listed entries read as zero.
    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        logic [15:0]   v;
        logic [DW-1:0] w;
        case (int'(a))
            0:       v = 16'hF200;
            1:       v = 16'h4000;
            2:       v = 16'hF800;
            3:       v = 16'h1007;
            4:       v = 16'hF400;
            5:       v = 16'h3007;
            6:       v = 16'h4000;
            default: v = 16'h0000;
        endcase
        w       = '0;
        w[15:0] = v;
        return w;
    endfunction

    // Request decode and read-data selection.
    // A request that coincides with reset is never accepted.
    always_comb begin
        rd_acc  = cs & ready & ~rst & ~we;
        wr_ram  = cs & ready & ~rst & we & (addr >= ROM_LIM);
        wr_rom  = cs & ready & ~rst & we & (addr < ROM_LIM);
        clr_we  = (state == S_CLEAR) & ~rst;
`ifdef BOOTMEM_PATCH_EN
        patch_ld = wr_rom & patch_unlock;
        err_set  = wr_rom & ~patch_unlock;
`else
        err_set  = wr_rom;
`endif
        rd_word = mem[addr];
        if (addr < ROM_LIM) begin
            rd_word = rom_word(addr);
`ifdef BOOTMEM_PATCH_EN
            if (patch_vld && (addr == patch_addr))
                rd_word = patch_data;
`endif
        end
    end

    // Control: clear sequencer, handshake, read strobe/data and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_CLEAR;
            clr_ptr <= ROM_LIM;
            ready   <= 1'b0;
            rvalid  <= 1'b0;
            dout    <= '0;
            err     <= 1'b0;
`ifdef BOOTMEM_PATCH_EN
            patch_vld <= 1'b0;
`endif
        end else begin
            rvalid <= rd_acc;
            if (rd_acc)
                dout <= rd_word;
            // A new violation wins over a simultaneous clear.
            if (err_set)
                err <= 1'b1;
            else if (clr_err)
                err <= 1'b0;
`ifdef BOOTMEM_PATCH_EN
            if (patch_ld)
                patch_vld <= 1'b1;
`endif
            case (state)
                S_CLEAR: begin
                    if (clr_ptr == LAST) begin
                        state <= S_IDLE;
                        ready <= 1'b1;
                    end else begin
                        clr_ptr <= clr_ptr + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM write port: the clear sequencer has priority over bus writes.
    always_ff @(posedge clk) begin
        if (clr_we)
            mem[clr_ptr] <= '0;
        else if (wr_ram)
            mem[addr] <= din;
    end

`ifdef BOOTMEM_PATCH_EN
    // Patch slot contents. Only patch_vld is reset.
    always_ff @(posedge clk) begin
        if (patch_ld) begin
            patch_addr <= addr;
            patch_data <= din;
        end
    end
`endif

endmodule

// File: tb/tb_bootmem_ctrl.sv
// Scoreboard bench for bootmem_ctrl with default parameters (DW=16, AW=5, ROM_WORDS=8).
// Inputs are driven on the falling edge. Outputs are sampled on the falling edge.
module tb_bootmem_ctrl;

    localparam int DW = 16;
    localparam int AW = 5;
    localparam int RW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cs;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          clr_err;
    logic          ready;
    logic [DW-1:0] dout;
    logic          rvalid;
    logic          err;
`ifdef BOOTMEM_PATCH_EN
    logic          patch_unlock;
`endif

    int            checks = 0;
    int            errors = 0;
    int            rv_cnt = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mon_exp;

    logic [15:0]   img [8] = '{16'hF200, 16'h4000, 16'hF800, 16'h1007,
                               16'hF400, 16'h3007, 16'h4000, 16'h0000};

    always #5 clk = ~clk;

    bootmem_ctrl #(.DW(DW), .AW(AW), .ROM_WORDS(RW)) dut (
        .clk     (clk),
        .rst     (rst),
        .cs      (cs),
        .we      (we),
        .addr    (addr),
        .din     (din),
        .clr_err (clr_err),
`ifdef BOOTMEM_PATCH_EN
        .patch_unlock (patch_unlock),
`endif
        .ready   (ready),
        .dout    (dout),
        .rvalid  (rvalid),
        .err     (err)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor: every rvalid pops one expected word from the scoreboard.
    always @(negedge clk) begin
        if (rvalid === 1'b1) begin
            rv_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid: dout %h with no read pending", dout);
            end else begin
                mon_exp = exp_q.pop_front();
                check("read_data", dout, mon_exp);
            end
        end
    end

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
        cs = 1'b1; we = 1'b0; addr = a;
        exp_q.push_back(e);
        @(negedge clk);
        cs = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cs = 1'b1; we = 1'b1; addr = a; din = d;
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL %s: ready still %b after %0d cycles, expected 1", name, ready, n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        logic bad;
        rst = 1'b1; cs = 1'b0; we = 1'b0; clr_err = 1'b0; addr = '0; din = '0;
`ifdef BOOTMEM_PATCH_EN
        patch_unlock = 1'b0;
`endif
        @(negedge clk);
        check("rst_ready",  {15'd0, ready},  16'd0);
        check("rst_rvalid", {15'd0, rvalid}, 16'd0);
        check("rst_dout",   dout,            16'h0000);
        check("rst_err",    {15'd0, err},    16'd0);
        rst = 1'b0;

        // Test 1: clear phase length, outputs quiet throughout
        n = 0; bad = 1'b0;
        while (ready !== 1'b1 && n < 100) begin
            n++;
            if (dout !== 16'h0 || err !== 1'b0 || rvalid !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        check("clear_cycles", 16'(n), 16'd24);
        check("clear_quiet",  {15'd0, bad}, 16'd0);

        // Test 2: back-to-back image readout
        base = rv_cnt;
        for (int i = 0; i < 8; i++) rd(AW'(i), img[i]);
        @(negedge clk);
        check("b2b_rvalid_count", 16'(rv_cnt - base), 16'd8);

        // Test 3: RAM write/read and cleared word
        wr(5'd8, 16'hA5A5);
        wr(5'd31, 16'h1234);
        check("dout_hold_on_write", dout, 16'h0000);
        rd(5'd8, 16'hA5A5);
        rd(5'd31, 16'h1234);
        rd(5'd9, 16'h0000);
        @(negedge clk);

        // Test 4: ROM protection and err clear priority
        wr(5'd3, 16'hBEEF);
        check("err_on_rom_write", {15'd0, err}, 16'd1);
        rd(5'd3, 16'h1007);
        clr_err = 1'b1; cs = 1'b1; we = 1'b1; addr = 5'd2; din = 16'hFFFF;
        @(negedge clk);
        clr_err = 1'b0; cs = 1'b0; we = 1'b0;
        check("err_set_beats_clr", {15'd0, err}, 16'd1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("err_cleared", {15'd0, err}, 16'd0);
        rd(5'd2, 16'hF800);
        @(negedge clk);

        // Test 5: reset with err set and a read in flight, then busy gating
        wr(5'd1, 16'h0000);
        check("err_before_rst", {15'd0, err}, 16'd1);
        rst = 1'b1; cs = 1'b1; we = 1'b0; addr = 5'd0;
        @(negedge clk);
        rst = 1'b0; cs = 1'b0;
        check("rst2_err",    {15'd0, err},    16'd0);
        check("rst2_dout",   dout,            16'h0000);
        check("rst2_rvalid", {15'd0, rvalid}, 16'd0);
        check("rst2_ready",  {15'd0, ready},  16'd0);
        @(negedge clk);
        @(negedge clk);
        wr(5'd20, 16'h5555);
        wr(5'd9, 16'h5555);
        cs = 1'b1; we = 1'b0; addr = 5'd0;
        @(negedge clk);
        cs = 1'b0;
        wr(5'd2, 16'h1111);
        check("busy_no_err", {15'd0, err}, 16'd0);
        wait_ready("ready_after_rst2");
        rd(5'd9, 16'h0000);
        rd(5'd20, 16'h0000);
        wr(5'd20, 16'h7777);
        rd(5'd20, 16'h7777);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_ready("ready_after_rst3");
        rd(5'd20, 16'h0000);
        @(negedge clk);

`ifdef BOOTMEM_PATCH_EN
        // Test 6: patch slot
        patch_unlock = 1'b1;
        wr(5'd5, 16'h0ABC);
        patch_unlock = 1'b0;
        check("patch_no_err", {15'd0, err}, 16'd0);
        rd(5'd5, 16'h0ABC);
        rd(5'd4, 16'hF400);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_ready("ready_after_patch_rst");
        rd(5'd5, 16'h3007);
        @(negedge clk);
`endif

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
